uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16: clk cycles per serial bit; legal range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 wr_en  input  1  byte-write strobe from SoC peripheral bus, one byte per asserted cycle.
REQ-006 wr_data  input  8  byte to transmit, sampled when wr_en=1.
REQ-007 wr_ready  output  1  high when FIFO count < FIFO_DEPTH.
REQ-008 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
REQ-009 busy  output  1  high while the serializer is outside IDLE or FIFO non-empty.
REQ-010 txd  output  1  serial line, 8N1, idle high.

Function
REQ-011 Write accepted on a rising edge when wr_en=1 and wr_ready=1; wr_data is appended at the tail.
REQ-012 Write with wr_ready=0 is dropped silently; FIFO contents and count unchanged.
REQ-013 wr_ready derives from the registered count only; a pop in the same cycle does not make a full FIFO accept a write.
REQ-014 Simultaneous accepted push and pop leaves fifo_count unchanged; data order is preserved.
REQ-015 Serializer FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: txd=1; on an edge with FIFO non-empty, pop head into shift register, clear bit counter, load divider, go START.
REQ-017 START: txd=0 for exactly CLK_DIV cycles, then DATA.
REQ-018 DATA: txd=shift[0] for CLK_DIV cycles per bit, LSB first, 8 bits, then STOP.
REQ-019 STOP: txd=1 for CLK_DIV cycles; at the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go IDLE.
REQ-020 Frame length is exactly 10*CLK_DIV cycles; the divider counts CLK_DIV-1 down to 0, with wrap on reload.
REQ-021 Latency: byte written on edge N into an empty FIFO with FSM in IDLE -> pop and txd=0 from edge N+1.
REQ-022 CLK_DIV=1 supported: each bit lasts one cycle; back-to-back frames are contiguous.
REQ-023 txd is driven from a flop (glitch-free).

Reset
REQ-024 rst_n low forces, without waiting for clk: FSM=IDLE, txd=1, fifo_count=0, wr_ready=1, busy=0, FIFO pointers=0, divider and bit counter=0.
REQ-025 Reset mid-frame aborts the frame, discards queued bytes, and drives txd high immediately.
REQ-026 After rst_n deasserts, the first write is accepted on the first rising edge.

Structure
REQ-027 Package uart_pkg holds the FSM state enum, the constants DATA_BITS=8 and FRAME_BITS=10, and the width helper for the count.
REQ-028 The FIFO is the sub-module uart_fifo: push, pop, dout, count, full, empty; reset is the same asynchronous active-low reset.
REQ-029 uart_tx instantiates uart_fifo plus FSM, divider, bit counter, and shift register; no other hierarchy.

Verification
REQ-030 CLK_DIV=4, write 0x55 once -> txd low from edge N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high for 4 cycles; busy drops after 40 cycles.
REQ-031 FIFO_DEPTH=8, CLK_DIV=16, 10 consecutive writes 0x00..0x09 in the first 10 cycles -> wr_ready=0 once the count reaches 8; the write of 0x09 is dropped; the line carries 0x00..0x08 with no idle gap.
REQ-032 Two writes 0xA5 then 0x3C -> second start bit begins the cycle after the first stop bit ends; total busy period 20*CLK_DIV+1 cycles.
REQ-033 Assert rst_n low mid-DATA of byte 0xFF with 3 queued -> txd=1 and fifo_count=0 asynchronously; after release, no further frame appears.
REQ-034 CLK_DIV=1, write 0x80 -> txd sequence 0,0,0,0,0,0,0,0,1,1 over 10 consecutive cycles.
REQ-035 FIFO full, simultaneous wr_en and STOP-end pop -> write dropped, fifo_count goes from 8 to 7.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: serializer states,
// frame geometry and the FIFO occupancy width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

   // Occupancy counter must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Transmit byte FIFO: power-of-two depth, registered occupancy count,
// full/empty derived from the count only.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every _d gets a default before any condition, so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding a START/DATA/STOP serializer
// with a reloadable clock divider; stop-to-start chaining leaves no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         busy,
   output logic                         txd
);

   localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);
   localparam int          BIT_CNT_W  = $clog2(FRAME_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [15:0]          div_q, div_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 txd_q, txd_d;

   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_dout;
   logic       div_done;

   uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .din   (wr_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign wr_ready = !fifo_full;
   assign busy     = (state_q != IDLE) || !fifo_empty;
   assign txd      = txd_q;
   assign div_done = (div_q == '0);

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               bit_cnt_d = '0;
               div_d     = DIV_RELOAD;
               state_d   = START;
            end
         end
         START: begin
            if (div_done) begin
               div_d   = DIV_RELOAD;
               state_d = DATA;
            end else begin
               div_d = div_q - 16'd1;
            end
         end
         DATA: begin
            if (div_done) begin
               div_d = DIV_RELOAD;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end else begin
               div_d = div_q - 16'd1;
            end
         end
         STOP: begin
            if (!div_done) begin
               div_d = div_q - 16'd1;
            end else if (!fifo_empty) begin
               // Chain straight into the next start bit.
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               bit_cnt_d = '0;
               div_d     = DIV_RELOAD;
               state_d   = START;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the next state so txd leaves a flop aligned with it.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (CLK_DIV 1, 4, 16) exercised by a
// vector table plus hand-written multi-cycle sequences.
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       wr_en1 = 1'b0, wr_en4 = 1'b0, wr_en16 = 1'b0;
   logic [7:0] wr_data1 = '0, wr_data4 = '0, wr_data16 = '0;
   logic       wr_ready1, wr_ready4, wr_ready16;
   logic [3:0] fifo_count1, fifo_count4, fifo_count16;
   logic       busy1, busy4, busy16;
   logic       txd1, txd4, txd16;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLK_DIV(1), .FIFO_DEPTH(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1),
      .wr_ready(wr_ready1), .fifo_count(fifo_count1), .busy(busy1), .txd(txd1)
   );

   uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en4), .wr_data(wr_data4),
      .wr_ready(wr_ready4), .fifo_count(fifo_count4), .busy(busy4), .txd(txd4)
   );

   uart_tx #(.CLK_DIV(16), .FIFO_DEPTH(8)) dut16 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en16), .wr_data(wr_data16),
      .wr_ready(wr_ready16), .fifo_count(fifo_count16), .busy(busy16), .txd(txd16)
   );

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_data;
      logic       exp_txd;
      logic       exp_busy;
      logic [3:0] exp_count;
      logic       exp_ready;
   } vec_t;

   vec_t vecs [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Expected line level k edges after the first write into the CLK_DIV=4 instance.
   function automatic logic exp_line4(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                      input int nframes);
      logic [9:0] fr;
      int         f, slot;
      if (k < 1 || k > 40 * nframes) return 1'b1;
      f    = (k - 1) / 40;
      slot = ((k - 1) % 40) / 4;
      fr   = {1'b1, (f == 0) ? b0 : b1, 1'b0};
      return fr[slot];
   endfunction

   task automatic send_and_watch4(input logic [7:0] b0, input logic [7:0] b1, input int nframes,
                                  input string tag);
      int busy_cycles = 0;
      wr_en4   = 1'b1;
      wr_data4 = b0;
      for (int k = 0; k <= 40 * nframes + 1; k++) begin
         @(negedge clk);
         check($sformatf("%s txd k=%0d", tag, k), 32'(txd4), 32'(exp_line4(k, b0, b1, nframes)));
         check($sformatf("%s busy k=%0d", tag, k), 32'(busy4), 32'(k <= 40 * nframes));
         if (busy4) busy_cycles++;
         if (k == 0 && nframes == 2) wr_data4 = b1;
         else wr_en4 = 1'b0;
      end
      check($sformatf("%s busy_cycles", tag), 32'(busy_cycles), 32'(40 * nframes + 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         exp_cnt [10];
      logic [9:0] frames [9];
      int         low_or_busy;

      // CLK_DIV=1: 0x80 then 0x01 written back-to-back; frames must be contiguous.
      vecs[0]  = '{1'b1, 8'h80, 1'b1, 1'b1, 4'd1, 1'b1};
      vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b1};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd1, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd1, 1'b1};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1};
      vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
      vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1};
      exp_cnt = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset txd4", 32'(txd4), 32'd1);
      check("reset busy4", 32'(busy4), 32'd0);
      check("reset count4", 32'(fifo_count4), 32'd0);
      check("reset ready4", 32'(wr_ready4), 32'd1);
      check("reset txd1", 32'(txd1), 32'd1);
      check("reset txd16", 32'(txd16), 32'd1);
      rst_n = 1'b1;

      // Table: row 0 is driven for the very first edge after reset release.
      for (int i = 0; i < 22; i++) begin
         wr_en1   = vecs[i].wr_en;
         wr_data1 = vecs[i].wr_data;
         @(negedge clk);
         check($sformatf("vec%0d txd", i), 32'(txd1), 32'(vecs[i].exp_txd));
         check($sformatf("vec%0d busy", i), 32'(busy1), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d count", i), 32'(fifo_count1), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d ready", i), 32'(wr_ready1), 32'(vecs[i].exp_ready));
      end
      wr_en1 = 1'b0;

      // CLK_DIV=4: single frame, then two chained frames.
      send_and_watch4(8'h55, 8'h00, 1, "one55");
      repeat (3) @(negedge clk);
      send_and_watch4(8'hA5, 8'h3C, 2, "a5_3c");
      repeat (3) @(negedge clk);

      // Reset in the middle of the data bits of 0xFF with three bytes queued.
      wr_en4   = 1'b1;
      wr_data4 = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) wr_data4 = 8'h11 * 8'(i + 1);
         else wr_en4 = 1'b0;
      end
      check("midreset queued", 32'(fifo_count4), 32'd3);
      repeat (12) @(negedge clk);
      check("midreset busy before", 32'(busy4), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset async txd", 32'(txd4), 32'd1);
      check("midreset async count", 32'(fifo_count4), 32'd0);
      check("midreset async busy", 32'(busy4), 32'd0);
      check("midreset async ready", 32'(wr_ready4), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      low_or_busy = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!txd4 || busy4) low_or_busy++;
      end
      check("postreset no frame", 32'(low_or_busy), 32'd0);
      check("postreset count", 32'(fifo_count4), 32'd0);

      // CLK_DIV=16: ten writes into an 8-deep FIFO, then a write colliding with a STOP-end pop.
      wr_en16   = 1'b1;
      wr_data16 = 8'h00;
      for (int e = 1; e <= 1445; e++) begin
         int rel;
         @(negedge clk);
         if (e <= 10) begin
            check($sformatf("fill count e=%0d", e), 32'(fifo_count16), 32'(exp_cnt[e-1]));
            check($sformatf("fill ready e=%0d", e), 32'(wr_ready16), 32'(e < 9));
         end
         rel = e - 2;
         if (rel >= 0 && rel < 1440 && rel % 16 == 8) frames[rel / 160][(rel % 160) / 16] = txd16;
         if (e == 161) check("full before pop", 32'(fifo_count16), 32'd8);
         if (e == 162) begin
            check("pop with dropped write count", 32'(fifo_count16), 32'd7);
            check("pop with dropped write ready", 32'(wr_ready16), 32'd1);
         end
         if (e == 1441) check("last frame busy", 32'(busy16), 32'd1);
         if (e == 1442) begin
            check("after last frame busy", 32'(busy16), 32'd0);
            check("after last frame txd", 32'(txd16), 32'd1);
         end
         if (e < 10) begin
            wr_en16   = 1'b1;
            wr_data16 = 8'(e);
         end else if (e == 161) begin
            wr_en16   = 1'b1;
            wr_data16 = 8'hEE;
         end else begin
            wr_en16 = 1'b0;
         end
      end
      for (int j = 0; j < 9; j++)
         check($sformatf("burst frame %0d", j), 32'(frames[j]), 32'({1'b1, 8'(j), 1'b0}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
